// File: rtl/mul8_seq.sv
// mul8_seq: sequential 8x8 unsigned multiplier. One 4x4 array multiplier is
// time-shared over four partial-product steps that accumulate a 16-bit
// product. Valid/ready handshakes on both sides, one operation in flight.
module mul8_seq #(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] p_o,
    output logic        busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  ra_q, ra_d;
    logic [7:0]  rb_q, rb_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;
    logic        skip_q, skip_d;

    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  pp;
    logic [15:0] pp_sh;

    // Nibble select: step[0] picks the high nibble of ra, step[1] that of rb.
    always_comb begin
        mul_a = step_q[0] ? ra_q[7:4] : ra_q[3:0];
        mul_b = step_q[1] ? rb_q[7:4] : rb_q[3:0];
    end

    // Shared 4x4 array multiplier (mul_lrtl): sum of the gated, shifted rows.
    always_comb begin
        pp = 8'd0;
        for (int i = 0; i < 4; i++) begin
            pp = pp + ({4'd0, mul_a & {4{mul_b[i]}}} << i);
        end
    end

    // Align the zero-extended partial product to its weight for this step.
    always_comb begin
        pp_sh = 16'd0;
        unique case (step_q)
            2'd0:    pp_sh = {8'd0, pp};
            2'd1:    pp_sh = {4'd0, pp, 4'd0};
            2'd2:    pp_sh = {4'd0, pp, 4'd0};
            default: pp_sh = {pp, 8'd0};
        endcase
    end

    // Next-state logic for the controller and datapath registers.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        step_d  = step_q;
        skip_d  = skip_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    ra_d    = a_i;
                    rb_d    = b_i;
                    acc_d   = 16'd0;
                    step_d  = 2'd0;
                    skip_d  = ZERO_SKIP && ((a_i == 8'd0) || (b_i == 8'd0));
                    state_d = StMul;
                end
            end
            StMul: begin
                if (skip_q) begin
                    // Zero operand: retire after one cycle with acc still 0.
                    state_d = StDone;
                end else begin
                    acc_d  = acc_q + pp_sh;
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                    step_d  = 2'd0;
                    skip_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ra_q    <= 8'd0;
            rb_q    <= 8'd0;
            acc_q   <= 16'd0;
            step_q  <= 2'd0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            skip_q  <= skip_d;
        end
    end

    // Handshake and result outputs decoded from the state.
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        busy_o      = (state_q != StIdle);
        p_o         = acc_q;
    end

endmodule

// File: tb/tb_mul8_seq.sv
// Directed bench for mul8_seq: handshake timing, products, back-pressure,
// zero-skip on both parameter settings, asynchronous reset and a random sweep.
module tb_mul8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a_i, b_i;
    logic [15:0] p;
    logic        in_valid_nz, in_ready_nz, out_valid_nz, out_ready_nz, busy_nz;
    logic [15:0] p_nz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul8_seq #(.ZERO_SKIP(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a_i),
        .b_i        (b_i),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .p_o        (p),
        .busy_o     (busy)
    );

    mul8_seq #(.ZERO_SKIP(1'b0)) dut_nz (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_nz),
        .in_ready_o (in_ready_nz),
        .a_i        (a_i),
        .b_i        (b_i),
        .out_valid_o(out_valid_nz),
        .out_ready_i(out_ready_nz),
        .p_o        (p_nz),
        .busy_o     (busy_nz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands in IDLE, let the accept edge pass, then scramble inputs.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        a_i      = a;
        b_i      = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a_i      = ~a;
        b_i      = ~b;
    endtask

    // Count edges after the accept edge until out_valid, then check the product.
    task automatic wait_result(input string tag, input int exp_lat, input logic [15:0] exp_p,
                               input bit chk_busy);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            if (chk_busy) begin
                check({tag, "_busy"}, busy, 1);
                check({tag, "_in_ready_low"}, in_ready, 0);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_p"}, p, exp_p);
    endtask

    // Hold the result for some cycles, then complete the output handshake.
    task automatic finish_op(input string tag, input int stall, input logic [15:0] exp_p);
        for (int i = 0; i < stall; i++) begin
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_p"}, p, exp_p);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_dropped"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         lat;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_valid_nz  = 1'b0;
        out_ready_nz = 1'b0;
        a_i          = 8'h00;
        b_i          = 8'h00;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_p", p, 16'h0000);
        check("rst_nz_in_ready", in_ready_nz, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic product and cross-term / max-operand cases.
        start_op(8'h0F, 8'h0F);
        wait_result("basic", 4, 16'h00E1, 1'b1);
        finish_op("basic", 2, 16'h00E1);

        start_op(8'hA5, 8'h3C);
        wait_result("cross", 4, 16'h26AC, 1'b1);
        finish_op("cross", 1, 16'h26AC);

        start_op(8'hFF, 8'hFF);
        wait_result("max", 4, 16'hFE01, 1'b1);
        finish_op("max", 0, 16'hFE01);

        // Back-pressure: 10 stalled cycles with a competing 1*1 request.
        start_op(8'hFF, 8'hFF);
        wait_result("bp", 4, 16'hFE01, 1'b0);
        a_i      = 8'h01;
        b_i      = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_p", p, 16'hFE01);
            check("bp_no_accept", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_after_release", in_ready, 1);
        check("bp_valid_dropped", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("bp_pending_1x1", 4, 16'h0001, 1'b1);
        finish_op("bp_pending_1x1", 0, 16'h0001);

        // Zero skip enabled.
        start_op(8'h00, 8'h77);
        wait_result("zskip_a0", 1, 16'h0000, 1'b1);
        finish_op("zskip_a0", 1, 16'h0000);
        start_op(8'h5A, 8'h00);
        wait_result("zskip_b0", 1, 16'h0000, 1'b1);
        finish_op("zskip_b0", 0, 16'h0000);

        // Zero skip disabled: full sequence even for a zero operand.
        @(negedge clk);
        check("nz_in_ready", in_ready_nz, 1);
        a_i         = 8'h00;
        b_i         = 8'h77;
        in_valid_nz = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_nz = 1'b0;
        lat = 0;
        while (!out_valid_nz && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("nz_latency", lat, 4);
        check("nz_p", p_nz, 16'h0000);
        out_ready_nz = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_nz = 1'b0;
        check("nz_in_ready_back", in_ready_nz, 1);

        // Asynchronous reset while step 2 of 0xFF*0xFF is pending.
        start_op(8'hFF, 8'hFF);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", p, 16'h0000);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h12, 8'h34);
        wait_result("post_rst", 4, 16'h03A8, 1'b1);
        finish_op("post_rst", 0, 16'h03A8);

        // Random sweep with random output stalls; zero operands biased in.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) ra = 8'h00;
            if ($urandom_range(0, 9) == 0) rb = 8'h00;
            start_op(ra, rb);
            wait_result("rand", (ra == 8'h00 || rb == 8'h00) ? 1 : 4, 16'(ra) * 16'(rb), 1'b0);
            finish_op("rand", int'($urandom_range(0, 3)), 16'(ra) * 16'(rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
